ring_router_mux: RTL
====================

RING_ROUTER_MUX -- requirements
Module: ring_router_mux

Interface
REQ-001 Parameter: OUT_REG, default 1, 1 = registered output through a 2-entry skid buffer, 0 = combinational pass-through.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_ring  dii_channel.slave  data 16, first 1, last 1, valid 1, ready 1  traffic continuing around the ring (from upstream demux out_ring).
REQ-005 in_local  dii_channel.slave  same fields  traffic injected by the local endpoint.
REQ-006 out_ring  dii_channel.master  same fields  merged traffic to next ring hop.

Function
REQ-007 Block SHALL merge in_ring and in_local onto out_ring at packet (worm) granularity; beats of different packets SHALL never interleave.
REQ-008 A beat transfers on a port when valid & ready are both high at the rising edge; packet end is marked solely by last; first SHALL be forwarded unchanged and SHALL NOT affect arbitration.
REQ-009 Arbiter FSM states: IDLE, WORM_RING, WORM_LOCAL.
REQ-010 IDLE: grant computed combinationally in the same cycle; only one valid -> that input granted; both valid -> input not granted last time (round robin); none valid -> no grant.
REQ-011 IDLE -> WORM_x when granted input x transfers a beat with last=0; a single-beat packet (last=1) SHALL leave FSM in IDLE.
REQ-012 WORM_x: only input x granted regardless of other input's valid; WORM_x -> IDLE on transfer of a beat from x with last=1.
REQ-013 last_grant register SHALL update to x on the first transferred beat of each packet from x.
REQ-014 Non-granted input ready SHALL be 0; granted input ready SHALL equal the sink-side ready (REQ-015/016).
REQ-015 OUT_REG=0: out_ring.data/first/last/valid SHALL equal the granted input fields combinationally; granted ready = out_ring.ready; latency 0.
REQ-016 OUT_REG=1: 2-entry skid buffer; granted ready = buffer not full (registered, no combinational path from out_ring.ready); out_ring driven from buffer head; latency exactly 1 cycle from input transfer to out_ring.valid when buffer empty.
REQ-017 OUT_REG=1: simultaneous push and pop SHALL keep occupancy unchanged; full buffer SHALL deassert granted ready; empty buffer SHALL hold out_ring.valid=0; order preserved, no beat dropped or duplicated.
REQ-018 Sustained throughput SHALL be 1 beat/cycle when out_ring.ready is held high, including back-to-back packets from alternating inputs (arbitration adds no bubble).
REQ-019 out_ring.valid SHALL NOT depend on out_ring.ready; once asserted it SHALL hold with stable data/first/last until transfer.

Reset
REQ-020 On rst: FSM=IDLE, last_grant=LOCAL (first contention goes to ring), buffer occupancy 0, out_ring.valid=0, in_ring.ready=in_local.ready=0 during the reset cycle.
REQ-021 rst asserted mid-packet SHALL abandon the worm and flush buffered beats; no beat of the aborted packet SHALL appear on out_ring after reset deasserts.
REQ-022 out_ring.data/first/last are don't-care while out_ring.valid=0.

Verification
REQ-023 Single-beat from local: in_local data=0x0005,first=1,last=1, out_ring.ready=1 -> out_ring shows 0x0005 one cycle later (OUT_REG=1), FSM stays IDLE.
REQ-024 Contention after reset: both inputs present 3-beat packets same cycle -> ring packet (3 beats) fully output first, then local packet, no interleave, 6 consecutive cycles of out_ring.valid.
REQ-025 Worm lock: ring packet beat 1 accepted, then local valid asserted -> in_local.ready stays 0 until ring last beat accepted, then local granted next cycle.
REQ-026 Backpressure: out_ring.ready=0 for 5 cycles during a 4-beat packet -> exactly 2 beats buffered, granted ready=0, all 4 beats delivered in order after ready returns.
REQ-027 Round robin: both inputs continuously sending single-beat packets -> output alternates ring, local, ring, local at 1 beat/cycle.
REQ-028 Reset mid-packet: rst pulsed after beat 2 of a 4-beat ring packet -> out_ring.valid=0 the cycle after rst, subsequent fresh local packet delivered intact.

Source files
------------

// File: rtl/ring_router_mux.sv
// Ring router merge stage: joins through-ring and locally injected traffic onto the
// next ring hop, switching sources only at packet boundaries (round-robin on contention).
module ring_router_mux #(
   parameter int OUT_REG = 1,
   parameter int DATA_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_ring_data_i,
   input  logic              in_ring_first_i,
   input  logic              in_ring_last_i,
   input  logic              in_ring_valid_i,
   output logic              in_ring_ready_o,
   input  logic [DATA_W-1:0] in_local_data_i,
   input  logic              in_local_first_i,
   input  logic              in_local_last_i,
   input  logic              in_local_valid_i,
   output logic              in_local_ready_o,
   output logic [DATA_W-1:0] out_ring_data_o,
   output logic              out_ring_first_o,
   output logic              out_ring_last_o,
   output logic              out_ring_valid_o,
   input  logic              out_ring_ready_i
);

   typedef enum logic [1:0] {S_IDLE, S_WORM_RING, S_WORM_LOCAL} state_e;

   state_e            state_q, state_d;
   logic              last_local_q, last_local_d;
   logic              grant_ring, grant_local;
   logic              sink_ready, sel_ready;
   logic              sel_valid, sel_first, sel_last, xfer;
   logic [DATA_W-1:0] sel_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_local_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_local_q <= last_local_d;
      end
   end

   // The first beat taken while idle starts a packet; it records the winner for round robin.
   always_comb begin
      state_d      = state_q;
      last_local_d = last_local_q;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               last_local_d = grant_local;
               if (!sel_last) state_d = grant_local ? S_WORM_LOCAL : S_WORM_RING;
            end
         end
         S_WORM_RING, S_WORM_LOCAL: begin
            if (xfer && sel_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      grant_ring  = 1'b0;
      grant_local = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_ring_valid_i && in_local_valid_i) begin
               grant_ring  = last_local_q;
               grant_local = !last_local_q;
            end else begin
               grant_ring  = in_ring_valid_i;
               grant_local = !in_ring_valid_i && in_local_valid_i;
            end
         end
         S_WORM_RING:  grant_ring  = 1'b1;
         S_WORM_LOCAL: grant_local = 1'b1;
         default: ;
      endcase
   end

   assign sel_ready        = sink_ready && !rst;
   assign in_ring_ready_o  = grant_ring && sel_ready;
   assign in_local_ready_o = grant_local && sel_ready;
   assign sel_valid        = (grant_ring && in_ring_valid_i) || (grant_local && in_local_valid_i);
   assign sel_data         = grant_ring ? in_ring_data_i  : in_local_data_i;
   assign sel_first        = grant_ring ? in_ring_first_i : in_local_first_i;
   assign sel_last         = grant_ring ? in_ring_last_i  : in_local_last_i;
   assign xfer             = sel_valid && sel_ready;

   if (OUT_REG != 0) begin : gen_skid
      logic [DATA_W+1:0] buf_q [2];
      logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [1:0]        count_q, count_d;
      logic              pop;

      // Ready comes only from occupancy, so out_ring_ready_i never reaches the inputs.
      assign sink_ready       = (count_q != 2'd2);
      assign out_ring_valid_o = (count_q != 2'd0);
      assign pop              = out_ring_valid_o && out_ring_ready_i;
      assign {out_ring_first_o, out_ring_last_o, out_ring_data_o} = buf_q[rd_ptr_q];

      always_comb begin
         wr_ptr_d = xfer ? !wr_ptr_q : wr_ptr_q;
         rd_ptr_d = pop  ? !rd_ptr_q : rd_ptr_q;
         count_d  = count_q;
         case ({xfer, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: ;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
         end
      end

      always_ff @(posedge clk) begin
         if (xfer) buf_q[wr_ptr_q] <= {sel_first, sel_last, sel_data};
      end
   end else begin : gen_pass
      assign sink_ready       = out_ring_ready_i;
      assign out_ring_valid_o = sel_valid && !rst;
      assign out_ring_data_o  = sel_data;
      assign out_ring_first_o = sel_first;
      assign out_ring_last_o  = sel_last;
   end

endmodule
